// File: rtl/gb_timer_pkg.sv
// Shared types and constants for the DMG timer block.
// Register addresses, TAC rate select and FSM state encoding.
package gb_timer_pkg;

    localparam logic [15:0] DIV_ADDR  = 16'hFF04;
    localparam logic [15:0] TIMA_ADDR = 16'hFF05;
    localparam logic [15:0] TMA_ADDR  = 16'hFF06;
    localparam logic [15:0] TAC_ADDR  = 16'hFF07;
    localparam int          OVF_DELAY = 4;

    typedef enum logic [1:0] {
        SEL_4096   = 2'b00,
        SEL_262144 = 2'b01,
        SEL_65536  = 2'b10,
        SEL_16384  = 2'b11
    } tac_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        OVF_WAIT = 2'd1,
        RELOAD   = 2'd2
    } timer_state_t;

    function automatic logic div_tap(
        input logic [15:0] d,
        input tac_sel_t    s
    );
        logic b;
        case (s)
            SEL_4096:   b = d[9];
            SEL_262144: b = d[3];
            SEL_65536:  b = d[5];
            SEL_16384:  b = d[7];
            default:    b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gb_timer_div.sv
// 16-bit system divider with TAC tap mux and falling-edge detect.
// Edge detect is on the gated tick, so DIV/TAC writes can glitch TIMA.
module gb_timer_div
    import gb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       div_clr,
    input  logic [2:0] tac,
    output logic [7:0] div_hi,
    output logic       inc_pulse
);

    logic [15:0] div_cnt;
    logic        tick_sig;
    logic        tick_q;

    always_comb begin
        tick_sig = tac[2] & div_tap(div_cnt, tac_sel_t'(tac[1:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 16'h0000;
            tick_q  <= 1'b0;
        end else begin
            div_cnt <= div_clr ? 16'h0000 : div_cnt + 16'd1;
            tick_q  <= tick_sig;
        end
    end

    assign div_hi    = div_cnt[15:8];
    assign inc_pulse = tick_q & ~tick_sig;

endmodule

// File: rtl/gb_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC registers at FF04-FF07 and overflow FSM.
// TIMA overflow holds 00 for a few cycles before reloading from TMA.
module gb_timer
    import gb_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [7:0]  rdata,
    output logic        sel_hit,
    output logic        irq_timer
);

    localparam logic [1:0] CNT_LAST = 2'(OVF_DELAY - 1);

    timer_state_t state;
    logic [1:0]   cnt;
    logic [7:0]   tima;
    logic [7:0]   tma;
    logic [2:0]   tac;
    logic [7:0]   div_hi;
    logic         inc_pulse;

    logic hit_div, hit_tima, hit_tma, hit_tac, hit_any;
    logic wr_div, wr_tima, wr_tma, wr_tac;
    logic [7:0] rd_mux;

    assign hit_div  = (addr == DIV_ADDR);
    assign hit_tima = (addr == TIMA_ADDR);
    assign hit_tma  = (addr == TMA_ADDR);
    assign hit_tac  = (addr == TAC_ADDR);
    assign hit_any  = hit_div | hit_tima | hit_tma | hit_tac;

    assign wr_div  = wr_en & hit_div;
    assign wr_tima = wr_en & hit_tima;
    assign wr_tma  = wr_en & hit_tma;
    assign wr_tac  = wr_en & hit_tac;

    gb_timer_div u_div (
        .clk       (clk),
        .rst       (rst),
        .div_clr   (wr_div),
        .tac       (tac),
        .div_hi    (div_hi),
        .inc_pulse (inc_pulse)
    );

    always_comb begin
        rd_mux = 8'hFF;
        unique case (1'b1)
            hit_div:  rd_mux = div_hi;
            hit_tima: rd_mux = tima;
            hit_tma:  rd_mux = tma;
            hit_tac:  rd_mux = {5'b11111, tac};
            default:  rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata   <= 8'h00;
            sel_hit <= 1'b0;
        end else begin
            if (rd_en) begin
                rdata <= rd_mux;
            end
            sel_hit <= rd_en & hit_any;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tma <= 8'h00;
            tac <= 3'b000;
        end else begin
            if (wr_tma) tma <= wdata;
            if (wr_tac) tac <= wdata[2:0];
        end
    end

    // Ticks are dropped outside RUN; a TIMA write beats a same-cycle tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
            tima  <= 8'h00;
        end else begin
            case (state)
                RUN: begin
                    if (wr_tima) begin
                        tima <= wdata;
                    end else if (inc_pulse) begin
                        if (tima == 8'hFF) begin
                            tima  <= 8'h00;
                            cnt   <= 2'd0;
                            state <= OVF_WAIT;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                OVF_WAIT: begin
                    if (wr_tima) begin
                        tima  <= wdata;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 2'd1;
                        if (cnt == CNT_LAST) begin
                            state <= RELOAD;
                        end
                    end
                end
                RELOAD: begin
                    tima  <= wr_tma ? wdata : tma;
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign irq_timer = (state == RELOAD);

endmodule
